// File: rtl/dm_bus_arbiter_pkg.sv
// Shared definitions for the data-side bus arbiter: device address map,
// one-hot select bit positions and the arbiter state encoding.
package dm_bus_arbiter_pkg;

  localparam logic [31:0] DM_LO  = 32'h0000_0000;
  localparam logic [31:0] DM_HI  = 32'h0000_2FFF;
  localparam logic [31:0] TC0_LO = 32'h0000_7F00;
  localparam logic [31:0] TC0_HI = 32'h0000_7F0B;
  localparam logic [31:0] TC1_LO = 32'h0000_7F10;
  localparam logic [31:0] TC1_HI = 32'h0000_7F1B;
  localparam logic [31:0] IG_LO  = 32'h0000_7F20;
  localparam logic [31:0] IG_HI  = 32'h0000_7F23;

  localparam int SEL_DM  = 0;
  localparam int SEL_TC0 = 1;
  localparam int SEL_TC1 = 2;
  localparam int SEL_IG  = 3;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } arb_state_e;

  function automatic logic in_range(input logic [31:0] a,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/dm_bus_arbiter_bus_addr_decode.sv
// Combinational byte-address to one-hot device select decoder; shared with
// the M-stage exception logic so both agree on what counts as a mapped address.
module bus_addr_decode
  import dm_bus_arbiter_pkg::*;
(
  input  logic [31:0] addr,
  output logic [3:0]  sel
);

  // Each device window is checked independently; the windows never overlap.
  always_comb begin
    sel          = 4'b0000;
    sel[SEL_DM]  = in_range(addr, DM_LO, DM_HI);
    sel[SEL_TC0] = in_range(addr, TC0_LO, TC0_HI);
    sel[SEL_TC1] = in_range(addr, TC1_LO, TC1_HI);
    sel[SEL_IG]  = in_range(addr, IG_LO, IG_HI);
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Arbitrates the data-side bus between the CPU M stage and the DMA word
// loader; CPU favoured, DMA protected from starvation by a wait counter.
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_exc,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_byteen,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_err,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_sel,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [3:0]       cpu_sel_s;
  logic [3:0]       dma_sel_s;
  logic             cpu_live_s;
  logic             dma_ok_s;

  bus_addr_decode u_cpu_dec (.addr(cpu_addr), .sel(cpu_sel_s));
  bus_addr_decode u_dma_dec (.addr(dma_addr), .sel(dma_sel_s));

  assign cpu_live_s = cpu_req && !cpu_exc;
  assign dma_ok_s   = dma_sel_s[SEL_DM] && (dma_addr[1:0] == 2'b00);

  // State, starvation count and held read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Arbitration, bus steering and next-state logic.
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    cpu_stall  = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_rdata  = rdata_q;
    dma_gnt    = 1'b0;
    dma_err    = 1'b0;
    bus_addr   = 32'h0000_0000;
    bus_byteen = 4'b0000;
    bus_wdata  = 32'h0000_0000;
    bus_sel    = 4'b0000;

    case (state_q)
      ST_IDLE: begin
        if (dma_req && (!cpu_live_s || (cnt_q == LIMIT_C))) begin
          dma_gnt   = 1'b1;
          bus_addr  = dma_addr;
          bus_wdata = dma_wdata;
          cpu_stall = cpu_live_s;
          if (dma_ok_s) begin
            bus_byteen = 4'b1111;
            bus_sel    = 4'b0001;
          end else begin
            dma_err = 1'b1;
          end
        end else if (cpu_live_s && cpu_we) begin
          bus_addr   = cpu_addr;
          bus_wdata  = cpu_wdata;
          bus_sel    = cpu_sel_s;
          bus_byteen = (cpu_sel_s != 4'b0000) ? cpu_byteen : 4'b0000;
        end else if (cpu_live_s && (cpu_sel_s != 4'b0000)) begin
          // Unmapped loads fall through: the upstream exception owns them.
          bus_addr  = cpu_addr;
          bus_sel   = cpu_sel_s;
          cpu_stall = 1'b1;
          state_d   = ST_RD_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        cpu_rvalid = 1'b1;
        cpu_rdata  = bus_rdata;
        rdata_d    = bus_rdata;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (dma_req && !dma_gnt) begin
      cnt_d = (cnt_q == LIMIT_C) ? cnt_q : (cnt_q + CNT_W'(1));
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end

    // Outputs are forced quiet for the whole reset cycle, including a read in flight.
    if (reset) begin
      cpu_stall  = 1'b0;
      cpu_rvalid = 1'b0;
      cpu_rdata  = 32'h0000_0000;
      dma_gnt    = 1'b0;
      dma_err    = 1'b0;
      bus_addr   = 32'h0000_0000;
      bus_byteen = 4'b0000;
      bus_wdata  = 32'h0000_0000;
      bus_sel    = 4'b0000;
    end else begin
      cpu_stall = cpu_stall;
    end
  end

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench for dm_bus_arbiter: directed scenarios plus a randomized
// run compared against a cycle-level reference model of the arbitration rules.
module tb_dm_bus_arbiter;

  localparam int LIMIT = 8;

  logic        clk;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_exc;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req;
  logic [31:0] dma_addr, dma_wdata;
  logic        dma_gnt, dma_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen, bus_sel;

  int total = 0;
  int bad   = 0;

  // {stall, rvalid, gnt, err, sel[3:0], byteen[3:0]}
  logic [11:0] obs;
  assign obs = {cpu_stall, cpu_rvalid, dma_gnt, dma_err, bus_sel, bus_byteen};

  dm_bus_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_exc(cpu_exc),
    .cpu_addr(cpu_addr), .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_err(dma_err),
    .bus_addr(bus_addr), .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_exc = 1'b0;
    cpu_addr = 32'h0; cpu_byteen = 4'h0; cpu_wdata = 32'h0;
    dma_req = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    bus_rdata = 32'h0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive_idle();
    next_cycle();
    reset = 1'b0;
  endtask

  function automatic logic [3:0] ref_sel(input logic [31:0] a);
    logic [3:0] s;
    s = 4'b0000;
    if (a <= 32'h2FFF) s = 4'b0001;
    else if (a >= 32'h7F00 && a <= 32'h7F0B) s = 4'b0010;
    else if (a >= 32'h7F10 && a <= 32'h7F1B) s = 4'b0100;
    else if (a >= 32'h7F20 && a <= 32'h7F23) s = 4'b1000;
    return s;
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    drive_idle();
    cpu_req = 1'b1; cpu_addr = 32'h7F04; dma_req = 1'b1; dma_addr = 32'h10;
    next_cycle();
    #2;
    total++;
    if (obs !== 12'h000 || cpu_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_active: got %h/%h want 000/0", obs, cpu_rdata);
    end
    reset = 1'b0;
    drive_idle();
    #1;
    total++;
    if (obs !== 12'h000 || bus_addr !== 32'h0 || cpu_rdata !== 32'h0) begin
      bad++; $display("FAIL reset_state: got %h/%h/%h want 000/0/0", obs, bus_addr, cpu_rdata);
    end
    next_cycle();
  endtask

  task automatic test_cpu_store;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_byteen = 4'hF; cpu_wdata = 32'hDEADBEEF;
    #2;
    total++;
    if (obs !== {4'b0000, 4'b0001, 4'b1111} || bus_addr !== 32'h10 || bus_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL cpu_store: got %h %h %h want 01f 00000010 deadbeef", obs, bus_addr, bus_wdata);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_cpu_load;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7F04;
    #2;
    total++;
    if (obs !== {4'b1000, 4'b0010, 4'b0000} || bus_addr !== 32'h7F04) begin
      bad++; $display("FAIL load_issue: got %h %h want 820 00007f04", obs, bus_addr);
    end
    next_cycle();
    bus_rdata = 32'h1234;
    #2;
    total++;
    if (obs !== {4'b0100, 4'b0000, 4'b0000} || cpu_rdata !== 32'h1234) begin
      bad++; $display("FAIL load_data: got %h %h want 400 00001234", obs, cpu_rdata);
    end
    next_cycle();
    drive_idle();
    bus_rdata = 32'hFFFF_FFFF;
    #2;
    total++;
    if (obs !== 12'h000 || cpu_rdata !== 32'h1234) begin
      bad++; $display("FAIL load_hold: got %h %h want 000 00001234", obs, cpu_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation;
    do_reset();
    dma_req = 1'b1; dma_addr = 32'h100; dma_wdata = 32'hCAFE0001;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_byteen = 4'hF; cpu_wdata = 32'h1111_1111;
    for (int i = 1; i <= LIMIT + 1; i++) begin
      #2;
      total++;
      if (i <= LIMIT) begin
        if (obs !== {4'b0000, 4'b0001, 4'b1111} || bus_addr !== 32'h20) begin
          bad++; $display("FAIL starve_cpu_wins c%0d: got %h %h want 01f 00000020", i, obs, bus_addr);
        end
      end else begin
        if (obs !== {4'b1010, 4'b0001, 4'b1111} || bus_addr !== 32'h100 || bus_wdata !== 32'hCAFE0001) begin
          bad++; $display("FAIL starve_grant c%0d: got %h %h %h want a1f 00000100 cafe0001", i, obs, bus_addr, bus_wdata);
        end
      end
      next_cycle();
    end
    dma_req = 1'b0;
    #2;
    total++;
    if (obs !== {4'b0000, 4'b0001, 4'b1111} || bus_addr !== 32'h20 || bus_wdata !== 32'h1111_1111) begin
      bad++; $display("FAIL starve_cpu_after: got %h %h %h want 01f 00000020 11111111", obs, bus_addr, bus_wdata);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_dma_err;
    logic [31:0] addrs [4];
    logic [11:0] want  [4];
    addrs[0] = 32'h7F00; want[0] = {4'b0011, 4'b0000, 4'b0000};
    addrs[1] = 32'h2FFC; want[1] = {4'b0010, 4'b0001, 4'b1111};
    addrs[2] = 32'h0002; want[2] = {4'b0011, 4'b0000, 4'b0000};
    addrs[3] = 32'h3000; want[3] = {4'b0011, 4'b0000, 4'b0000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dma_req = 1'b1; dma_addr = addrs[i]; dma_wdata = 32'hA5A5_0000 + i;
      #2;
      total++;
      if (obs !== want[i]) begin
        bad++; $display("FAIL dma_addr %h: got %h want %h", addrs[i], obs, want[i]);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_exc;
    do_reset();
    cpu_req = 1'b1; cpu_exc = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_byteen = 4'hF;
    dma_req = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h77;
    #2;
    total++;
    if (obs !== {4'b0010, 4'b0001, 4'b1111} || bus_addr !== 32'h40) begin
      bad++; $display("FAIL exc_with_dma: got %h %h want 21f 00000040", obs, bus_addr);
    end
    next_cycle();
    dma_req = 1'b0; cpu_we = 1'b0;
    #2;
    total++;
    if (obs !== 12'h000) begin
      bad++; $display("FAIL exc_alone: got %h want 000", obs);
    end
    next_cycle();
    drive_idle();
  endtask

  task automatic test_reset_mid_read;
    do_reset();
    dma_req = 1'b1; dma_addr = 32'h200;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h7F14;
    #2;
    total++;
    if (obs !== {4'b1000, 4'b0100, 4'b0000}) begin
      bad++; $display("FAIL rr_issue: got %h want 840", obs);
    end
    next_cycle();
    reset = 1'b1; bus_rdata = 32'hAAAA_5555;
    #2;
    total++;
    if (obs !== 12'h000 || cpu_rdata !== 32'h0) begin
      bad++; $display("FAIL rr_during: got %h %h want 000 0", obs, cpu_rdata);
    end
    next_cycle();
    reset = 1'b0; drive_idle();
    bus_rdata = 32'hAAAA_5555;
    for (int i = 0; i < 2; i++) begin
      #2;
      total++;
      if (obs !== 12'h000 || cpu_rdata !== 32'h0) begin
        bad++; $display("FAIL rr_after c%0d: got %h %h want 000 0", i, obs, cpu_rdata);
      end
      next_cycle();
    end
    // Starvation count must restart from zero after the reset.
    dma_req = 1'b1; dma_addr = 32'h300;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h30; cpu_byteen = 4'hF;
    for (int i = 1; i <= LIMIT + 1; i++) begin
      #2;
      total++;
      if (dma_gnt !== (i == LIMIT + 1)) begin
        bad++; $display("FAIL rr_cnt c%0d: gnt got %b want %b", i, dma_gnt, (i == LIMIT + 1));
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_random;
    bit          pend;
    int          wait_c;
    int          dut_age;
    logic [31:0] held;
    logic        live, e_stall, e_rv, e_gnt, e_err, next_pend, prev_stall;
    logic [3:0]  e_sel, e_be, csel;
    logic [31:0] e_addr, e_rdata;
    do_reset();
    pend = 1'b0; wait_c = 0; held = 32'h0; prev_stall = 1'b0; dut_age = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!dma_req && $urandom_range(0, 2) == 0) begin
        dma_req = 1'b1; dma_wdata = $urandom;
        case ($urandom_range(0, 4))
          0, 1, 2: dma_addr = $urandom_range(0, 32'h2FFF) & 32'hFFFF_FFFC;
          3:       dma_addr = $urandom_range(0, 32'h2FFF) | 32'h1;
          default: dma_addr = $urandom_range(32'h3000, 32'h7F23) & 32'hFFFF_FFFC;
        endcase
      end
      if (!prev_stall) begin
        cpu_req = ($urandom_range(0, 9) < 8); cpu_we = $urandom_range(0, 1);
        cpu_exc = ($urandom_range(0, 9) == 0);
        cpu_byteen = $urandom_range(1, 15); cpu_wdata = $urandom;
        case ($urandom_range(0, 5))
          0, 1:    cpu_addr = $urandom_range(0, 32'h2FFF);
          2:       cpu_addr = 32'h7F00 + $urandom_range(0, 11);
          3:       cpu_addr = 32'h7F10 + $urandom_range(0, 11);
          4:       cpu_addr = 32'h7F20 + $urandom_range(0, 3);
          default: cpu_addr = $urandom_range(32'h3000, 32'h7FFF);
        endcase
      end
      bus_rdata = $urandom;
      #2;
      e_stall = 1'b0; e_rv = 1'b0; e_gnt = 1'b0; e_err = 1'b0;
      e_sel = 4'h0; e_be = 4'h0; e_addr = 32'h0; next_pend = 1'b0;
      e_rdata = held;
      live = cpu_req && !cpu_exc;
      csel = ref_sel(cpu_addr);
      if (pend) begin
        e_rv = 1'b1; e_rdata = bus_rdata; held = bus_rdata;
      end else if (dma_req && (!live || wait_c >= LIMIT)) begin
        e_gnt = 1'b1; e_stall = live; e_addr = dma_addr;
        if (dma_addr < 32'h3000 && dma_addr % 4 == 0) begin
          e_sel = 4'b0001; e_be = 4'b1111;
        end else begin
          e_err = 1'b1;
        end
      end else if (live && cpu_we) begin
        e_sel = csel; e_addr = cpu_addr; e_be = (csel != 4'h0) ? cpu_byteen : 4'h0;
      end else if (live && csel != 4'h0) begin
        e_sel = csel; e_addr = cpu_addr; e_stall = 1'b1; next_pend = 1'b1;
      end
      total++;
      if (obs !== {e_stall, e_rv, e_gnt, e_err, e_sel, e_be} || cpu_rdata !== e_rdata) begin
        bad++; $display("FAIL rand c%0d: got %h %h want %h %h", cyc, obs, cpu_rdata,
                        {e_stall, e_rv, e_gnt, e_err, e_sel, e_be}, e_rdata);
      end
      if (e_sel != 4'h0) begin
        total++;
        if (bus_addr !== e_addr) begin
          bad++; $display("FAIL rand_addr c%0d: got %h want %h", cyc, bus_addr, e_addr);
        end
      end
      if (dma_req && !dma_gnt) dut_age++;
      if (dma_gnt) begin
        total++;
        if (dut_age + 1 > LIMIT + 2) begin
          bad++; $display("FAIL dma_latency: got %0d cycles want <= %0d", dut_age + 1, LIMIT + 2);
        end
        dut_age = 0;
      end
      wait_c = (dma_req && !e_gnt) ? ((wait_c + 1 > LIMIT) ? LIMIT : wait_c + 1) : 0;
      pend = next_pend;
      prev_stall = e_stall;
      next_cycle();
      if (e_gnt) dma_req = 1'b0;
    end
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_cpu_store();
    test_cpu_load();
    test_starvation();
    test_dma_err();
    test_exc();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
